// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RV64 pipeline: owns the PC, addresses the instruction memory,
// fills the IF/ID register and flags misaligned or out-of-range fetches.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = 148,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] Instruction,
    output logic [63:0] Inst_Address,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [0:0]  S_RUN      = 1'b0;
    localparam logic [0:0]  S_HALT     = 1'b1;
    localparam logic [63:0] LAST_LEGAL = 64'(IMEM_BYTES - 4);

    logic [0:0]  r_state;
    logic [63:0] r_pc;
    logic [63:0] r_ifIdPc;
    logic [31:0] r_ifIdInstr;
    logic        r_ifIdValid;
    logic        r_fault;
    logic [31:0] r_count;

    logic [63:0] w_pcPlus4;
    logic        w_targetBad;
    logic        w_seqBad;

    // Range checks happen before the PC update so an illegal address never reaches the memory.
    assign w_pcPlus4   = r_pc + 64'd4;
    assign w_targetBad = (branch_target[1:0] != 2'b00) || (branch_target > LAST_LEGAL);
    assign w_seqBad    = w_pcPlus4 > LAST_LEGAL;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_pc        <= RESET_PC;
            r_ifIdPc    <= 64'd0;
            r_ifIdInstr <= NOP_INSTR;
            r_ifIdValid <= 1'b0;
            r_fault     <= 1'b0;
            r_count     <= 32'd0;
        end else if (r_state == S_HALT) begin
            r_ifIdPc    <= 64'd0;
            r_ifIdInstr <= NOP_INSTR;
            r_ifIdValid <= 1'b0;
        end else if (branch_taken) begin
            r_ifIdPc    <= 64'd0;
            r_ifIdInstr <= NOP_INSTR;
            r_ifIdValid <= 1'b0;
            if (w_targetBad) begin
                r_state <= S_HALT;
                r_fault <= 1'b1;
            end else begin
                r_pc <= branch_target;
            end
        end else if (!stall) begin
            // The instruction at the last legal word is still delivered before halting.
            r_ifIdPc    <= r_pc;
            r_ifIdInstr <= Instruction;
            r_ifIdValid <= 1'b1;
            if (r_count != 32'hFFFF_FFFF) begin
                r_count <= r_count + 32'd1;
            end
            if (w_seqBad) begin
                r_state <= S_HALT;
                r_fault <= 1'b1;
            end else begin
                r_pc <= w_pcPlus4;
            end
        end
    end

    assign Inst_Address      = r_pc;
    assign if_id_pc          = r_ifIdPc;
    assign if_id_instruction = r_ifIdInstr;
    assign if_id_valid       = r_ifIdValid;
    assign fetch_fault       = r_fault;
    assign fetch_count       = r_count;

endmodule
